// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution stream driver slice.
//   conv_state_t  : driver FSM states
//   FP_W          : data word width (FP32, passed through bit-exact)
//   MAX_*_DEFAULT : default largest input / filter sides
//   addr_width()  : address bits needed for a RAM of a given depth
//   src_depth()   : words in the source buffer (input region + filter region)
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int FP_W           = 32;
    localparam int MAX_IN_DEFAULT = 16;
    localparam int MAX_F_DEFAULT  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_CAPTURE,
        ST_COMPLETE
    } conv_state_t;

    // Never returns less than one bit so tiny buffers still get a usable port.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // The filter region sits directly after the input region.
    function automatic int src_depth(input int max_in, input int max_f);
        return max_in * max_in + max_f * max_f;
    endfunction

endpackage

// File: rtl/conv_word_ram.sv
// -----------------------------------------------------------------------------
// conv_word_ram
// Simple dual-port synchronous RAM: one write port, one registered read port.
//   clk, rst          : clock; async active-high reset (clears the read register only)
//   wr_en/addr/data   : write port, out-of-range addresses are ignored
//   rd_en/addr        : read request, data appears on rd_data one cycle later
//   rd_data           : registered read data
// Memory contents are not reset and survive rst.
// -----------------------------------------------------------------------------
module conv_word_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok = {1'b0, rd_addr} < DEPTH_W;

    // Storage array: no reset so contents are preserved across rst.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/conv_stream_driver.sv
// -----------------------------------------------------------------------------
// conv_stream_driver
// Host-side driver for the convolution engine. Streams an N x N input matrix
// followed by an F x F filter, waits for the engine's done edge, captures the
// O x O result (O = N-F+1) and exposes it through a registered read port.
//   clk, rst                         : clock, async active-high reset
//   cfg_input_size, cfg_filter_size  : N and F, sampled on an accepted start
//   wr_en, wr_sel, wr_addr, wr_data  : host writes (sel 0 = input, 1 = filter)
//   start                            : launch a frame
//   busy                             : frame in progress
//   stream_data/valid/last           : word stream to the engine
//   conv_done, conv_data             : engine done and result stream
//   res_rd_addr, res_rd_data         : result read port, 1-cycle latency
//   res_count                        : words captured in the last frame
//   frame_done, error                : completion / rejection-or-timeout pulses
// -----------------------------------------------------------------------------
module conv_stream_driver
    import conv_pkg::*;
#(
    parameter int MAX_IN    = MAX_IN_DEFAULT,
    parameter int MAX_F     = MAX_F_DEFAULT,
    parameter int CAP_DELAY = 1,
    parameter int TIMEOUT   = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cfg_input_size,
    input  logic [7:0]      cfg_filter_size,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [7:0]      wr_addr,
    input  logic [FP_W-1:0] wr_data,
    input  logic            start,
    output logic            busy,
    output logic [FP_W-1:0] stream_data,
    output logic            stream_valid,
    output logic            stream_last,
    input  logic            conv_done,
    input  logic [FP_W-1:0] conv_data,
    input  logic [7:0]      res_rd_addr,
    output logic [FP_W-1:0] res_rd_data,
    output logic [15:0]     res_count,
    output logic            frame_done,
    output logic            error
);

    localparam int IN_DEPTH  = MAX_IN * MAX_IN;
    localparam int SRC_DEPTH = src_depth(MAX_IN, MAX_F);
    localparam int SRC_AW    = addr_width(SRC_DEPTH);
    localparam int RES_AW    = addr_width(IN_DEPTH);

    localparam logic [15:0] IN_DEPTH16  = 16'(IN_DEPTH);
    localparam logic [15:0] FLT_DEPTH16 = 16'(MAX_F * MAX_F);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
    localparam logic [15:0] DLY_LAST    = 16'(CAP_DELAY - 1);
    localparam logic [7:0]  MAX_IN8     = 8'(MAX_IN);
    localparam logic [7:0]  MAX_F8      = 8'(MAX_F);

    conv_state_t state, state_n;

    logic [7:0]  n_q, f_q, o_side;
    logic [15:0] nn, ff, oo, words_m1, oo_m1;
    logic [15:0] send_cnt, cap_cnt, wait_cnt, dly_cnt;
    logic        dly_active, done_q, done_rise;
    logic        cfg_bad, accept, reject, timeout_hit, dly_start;
    logic        src_re, res_we, wr_in_range, src_we;
    logic [SRC_AW-1:0] src_waddr, src_raddr;
    logic [FP_W-1:0]   src_rd_data;

    // Frame geometry from the latched sizes; all products are 8x8 unsigned.
    assign nn       = 16'(n_q) * 16'(n_q);
    assign ff       = 16'(f_q) * 16'(f_q);
    assign o_side   = n_q - f_q + 8'd1;
    assign oo       = 16'(o_side) * 16'(o_side);
    assign words_m1 = nn + ff - 16'd1;
    assign oo_m1    = oo - 16'd1;

    assign cfg_bad = (cfg_filter_size == 8'd0) || (cfg_filter_size > cfg_input_size)
                  || (cfg_input_size > MAX_IN8) || (cfg_filter_size > MAX_F8);

    assign done_rise = conv_done & ~done_q;

    // Host writes land in the source buffer only while idle and in range.
    assign wr_in_range = wr_sel ? ({8'd0, wr_addr} < FLT_DEPTH16)
                                : ({8'd0, wr_addr} < IN_DEPTH16);
    assign src_we      = wr_en && !busy && wr_in_range;
    assign src_waddr   = wr_sel ? (SRC_AW'(IN_DEPTH) + SRC_AW'(wr_addr)) : SRC_AW'(wr_addr);

    // Input words come first, then the filter region from its fixed base.
    assign src_raddr = (send_cnt < nn) ? SRC_AW'(send_cnt)
                                       : (SRC_AW'(IN_DEPTH) + SRC_AW'(send_cnt - nn));

    assign stream_data = stream_valid ? src_rd_data : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and single-cycle control strobes. The capture delay is
    // served inside WAIT_DONE by a small counter once the done edge is seen.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        reject      = 1'b0;
        timeout_hit = 1'b0;
        dly_start   = 1'b0;
        src_re      = 1'b0;
        res_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                src_re = 1'b1;
                if (send_cnt == words_m1) begin
                    state_n = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (dly_active) begin
                    if (dly_cnt == DLY_LAST) begin
                        state_n = ST_CAPTURE;
                    end
                end else if (done_rise) begin
                    if (CAP_DELAY <= 1) begin
                        state_n = ST_CAPTURE;
                    end else begin
                        dly_start = 1'b1;
                    end
                end else if (wait_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_n     = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                res_we = 1'b1;
                if (cap_cnt == oo_m1) begin
                    state_n = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Counters, latched sizes, edge detector and registered outputs.
    // stream_valid/last trail the read request by one cycle to match the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q          <= '0;
            f_q          <= '0;
            send_cnt     <= '0;
            cap_cnt      <= '0;
            wait_cnt     <= '0;
            dly_cnt      <= '0;
            dly_active   <= 1'b0;
            done_q       <= 1'b0;
            busy         <= 1'b0;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
            res_count    <= '0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
        end else begin
            done_q       <= conv_done;
            busy         <= (state_n != ST_IDLE);
            error        <= reject | timeout_hit;
            stream_valid <= src_re;
            stream_last  <= src_re && (send_cnt == words_m1);
            frame_done   <= (state == ST_CAPTURE) && (state_n == ST_COMPLETE);

            if (accept) begin
                n_q <= cfg_input_size;
                f_q <= cfg_filter_size;
            end

            if ((state == ST_CAPTURE) && (state_n == ST_COMPLETE)) begin
                res_count <= oo;
            end

            send_cnt <= (state == ST_SEND)      ? send_cnt + 16'd1 : 16'd0;
            cap_cnt  <= (state == ST_CAPTURE)   ? cap_cnt + 16'd1  : 16'd0;
            wait_cnt <= (state == ST_WAIT_DONE) ? wait_cnt + 16'd1 : 16'd0;

            if (dly_start) begin
                dly_active <= 1'b1;
                dly_cnt    <= 16'd1;
            end else if (state != ST_WAIT_DONE) begin
                dly_active <= 1'b0;
                dly_cnt    <= 16'd0;
            end else if (dly_active) begin
                dly_cnt <= dly_cnt + 16'd1;
            end
        end
    end

    conv_word_ram #(
        .DEPTH (SRC_DEPTH),
        .WIDTH (FP_W),
        .AW    (SRC_AW)
    ) u_src_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (src_we),
        .wr_addr (src_waddr),
        .wr_data (wr_data),
        .rd_en   (src_re),
        .rd_addr (src_raddr),
        .rd_data (src_rd_data)
    );

    conv_word_ram #(
        .DEPTH (IN_DEPTH),
        .WIDTH (FP_W),
        .AW    (RES_AW)
    ) u_res_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_we),
        .wr_addr (RES_AW'(cap_cnt)),
        .wr_data (conv_data),
        .rd_en   (1'b1),
        .rd_addr (RES_AW'(res_rd_addr)),
        .rd_data (res_rd_data)
    );

endmodule

// File: tb/tb_conv_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_conv_stream_driver
// Directed bench for conv_stream_driver. Expected stream words are queued when
// a frame is launched and popped by a stream monitor; the bench plays the
// engine, driving distinct result words only in the expected capture cycles.
// -----------------------------------------------------------------------------
module tb_conv_stream_driver;

    localparam int TB_CAP     = 3;
    localparam int TB_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_input_size, cfg_filter_size;
    logic        wr_en, wr_sel;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic [31:0] stream_data;
    logic        stream_valid, stream_last;
    logic        conv_done;
    logic [31:0] conv_data;
    logic [7:0]  res_rd_addr;
    logic [31:0] res_rd_data;
    logic [15:0] res_count;
    logic        frame_done, error;

    int n_checks = 0;
    int n_fails  = 0;
    int stream_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    logic [31:0] m_in [256];
    logic [31:0] m_flt [16];
    logic [15:0] exp_count = 16'd0;

    conv_stream_driver #(
        .MAX_IN    (16),
        .MAX_F     (4),
        .CAP_DELAY (TB_CAP),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_input_size  (cfg_input_size),
        .cfg_filter_size (cfg_filter_size),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .start           (start),
        .busy            (busy),
        .stream_data     (stream_data),
        .stream_valid    (stream_valid),
        .stream_last     (stream_last),
        .conv_done       (conv_done),
        .conv_data       (conv_data),
        .res_rd_addr     (res_rd_addr),
        .res_rd_data     (res_rd_data),
        .res_count       (res_count),
        .frame_done      (frame_done),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One host cycle: drive the write/start inputs, then release them.
    task automatic applyStimulus(input logic we, input logic sel, input logic [7:0] addr,
                                 input logic [31:0] data, input logic st);
        wr_en   = we;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        start   = st;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    function automatic logic [31:0] res_word(input int tag, input int k);
        return 32'h4100_0000 + 32'(tag * 256 + k);
    endfunction

    // Stream monitor: every valid word must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && stream_valid === 1'b1) begin
            stream_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("stream_unexpected", 64'(stream_valid), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("stream_word", 64'({stream_last, stream_data}), 64'(mon_exp));
            end
        end
    end

    task automatic push_frame(input int n, input int f);
        for (int k = 0; k < n * n; k++) exp_q.push_back({1'b0, m_in[k]});
        for (int k = 0; k < f * f; k++) exp_q.push_back({(k == f * f - 1), m_flt[k]});
        stream_cnt = 0;
    endtask

    // Full frame. gap < 0 means the engine never answers (timeout path).
    task automatic run_frame(input int n, input int f, input int gap, input bit poke_busy,
                             input bit co_write, input logic [31:0] co_data, input int tag);
        int w, o, oo, cyc;
        w  = n * n + f * f;
        o  = n - f + 1;
        oo = o * o;
        if (co_write) m_in[0] = co_data;
        push_frame(n, f);
        cfg_input_size  = 8'(n);
        cfg_filter_size = 8'(f);
        start = 1'b1;
        if (co_write) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = co_data;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        checkOutput("busy_rise", 64'(busy), 64'd1);
        cyc = 1;
        while (stream_last !== 1'b1 && cyc < 600) begin
            if (poke_busy && cyc == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0;
                wr_data = 32'hBADB_AD00;
            end
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            cyc++;
        end
        checkOutput("last_cycle", 64'(cyc), 64'(1 + w));
        #1;
        checkOutput("stream_count", 64'(stream_cnt), 64'(w));
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        if (gap < 0) begin
            cyc = 0;
            while (error !== 1'b1 && cyc < 3 * TB_TIMEOUT) begin
                @(negedge clk);
                cyc++;
                checkOutput("timeout_no_frame_done", 64'(frame_done), 64'd0);
            end
            checkOutput("timeout_cycle", 64'(cyc), 64'(TB_TIMEOUT));
            checkOutput("timeout_busy", 64'(busy), 64'd0);
            checkOutput("timeout_res_count", 64'(res_count), 64'(exp_count));
            @(negedge clk);
            checkOutput("timeout_error_pulse", 64'(error), 64'd0);
        end else begin
            repeat (gap) @(negedge clk);
            conv_done = 1'b1;
            conv_data = 32'hDEAD_0000;
            for (int c = 1; c <= TB_CAP + oo + 1; c++) begin
                @(negedge clk);
                if (c == 2) conv_done = 1'b0;
                conv_data = (c >= TB_CAP && c < TB_CAP + oo) ? res_word(tag, c - TB_CAP)
                                                             : (32'hDEAD_0000 | 32'(c));
                checkOutput("frame_done", 64'(frame_done), 64'(c == TB_CAP + oo));
                if (c == TB_CAP + oo) begin
                    exp_count = 16'(oo);
                    checkOutput("res_count", 64'(res_count), 64'(exp_count));
                    checkOutput("busy_in_complete", 64'(busy), 64'd1);
                end
                if (c == TB_CAP + oo + 1) checkOutput("busy_fall", 64'(busy), 64'd0);
            end
            conv_done = 1'b0;
            for (int k = 0; k < oo; k++) begin
                res_rd_addr = 8'(k);
                @(negedge clk);
                checkOutput("res_rd", 64'(res_rd_data), 64'(res_word(tag, k)));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_input_size = 8'd0; cfg_filter_size = 8'd0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 32'd0;
        start = 1'b0; conv_done = 1'b0; conv_data = 32'd0; res_rd_addr = 8'd0;
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_valid", 64'(stream_valid), 64'd0);
        checkOutput("rst_last", 64'(stream_last), 64'd0);
        checkOutput("rst_data", 64'(stream_data), 64'd0);
        checkOutput("rst_res_count", 64'(res_count), 64'd0);
        checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        checkOutput("rst_res_rd", 64'(res_rd_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Load 4x4 input and 2x2 filter.
        for (int k = 0; k < 16; k++) begin
            m_in[k] = 32'h3F80_0000 + 32'(k);
            applyStimulus(1'b1, 1'b0, 8'(k), m_in[k], 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            m_flt[k] = 32'h4000_0000;
            applyStimulus(1'b1, 1'b1, 8'(k), m_flt[k], 1'b0);
        end

        // Normal frame, with a second start and a write poked in during SEND.
        $display("[TB] normal 4x4 frame");
        run_frame(4, 2, 3, 1'b1, 1'b0, 32'd0, 1);

        // Rejected configurations.
        $display("[TB] invalid configurations");
        for (int i = 0; i < 3; i++) begin
            cfg_input_size  = (i == 0) ? 8'd4 : (i == 1) ? 8'd8 : 8'd17;
            cfg_filter_size = (i == 0) ? 8'd0 : (i == 1) ? 8'd5 : 8'd2;
            applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
            checkOutput("cfg_error", 64'(error), 64'd1);
            checkOutput("cfg_busy", 64'(busy), 64'd0);
            @(negedge clk);
            checkOutput("cfg_error_pulse", 64'(error), 64'd0);
            checkOutput("cfg_no_valid", 64'(stream_valid), 64'd0);
            repeat (3) @(negedge clk);
        end

        // Engine never answers.
        $display("[TB] timeout");
        run_frame(4, 2, -1, 1'b0, 1'b0, 32'd0, 2);

        // Reset in the middle of SEND, then restart.
        $display("[TB] reset mid-SEND");
        push_frame(4, 2);
        cfg_input_size = 8'd4; cfg_filter_size = 8'd2;
        applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        repeat (8) @(negedge clk);
        #1;
        checkOutput("mid_words_seen", 64'(stream_cnt), 64'd8);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_valid", 64'(stream_valid), 64'd0);
        checkOutput("mid_rst_last", 64'(stream_last), 64'd0);
        checkOutput("mid_rst_data", 64'(stream_data), 64'd0);
        checkOutput("mid_rst_res_count", 64'(res_count), 64'd0);
        checkOutput("mid_rst_frame_done", 64'(frame_done), 64'd0);
        checkOutput("mid_rst_error", 64'(error), 64'd0);
        rst = 1'b0;
        exp_count = 16'd0;
        @(negedge clk);
        run_frame(4, 2, 2, 1'b0, 1'b0, 32'd0, 3);

        // 1x1 frame with start and write in the same cycle.
        $display("[TB] 1x1 frame, capture delay");
        run_frame(1, 1, 1, 1'b0, 1'b1, 32'h3F00_ABCD, 4);

        repeat (2) @(negedge clk);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/conv_stream_driver.md
# conv_stream_driver

Host-side counterpart of the convolution engine. Holds one input matrix and one filter matrix, both FP32 and loaded by the host. On `start` it serialises them into the engine's one-word-per-clock data stream. It then waits for the engine's `done`, captures the result stream into a result buffer, and exposes that buffer to the host through a registered read port.

## Interface
- `MAX_IN`, 16: largest supported input_size; input region depth is MAX_IN*MAX_IN.
- `MAX_F`, 4: largest supported filter_size; filter region depth is MAX_F*MAX_F.
- `CAP_DELAY`, 1: cycles from the detected `conv_done` rising edge to the first captured word.
- `TIMEOUT`, 65535: maximum number of WAIT_DONE cycles before the error exit.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_input_size`  in  8  input matrix side; sampled on an accepted `start`.
- `cfg_filter_size`  in  8  filter side; sampled on an accepted `start`.
- `wr_en`  in  1  host write strobe into the source buffer.
- `wr_sel`  in  1  source region select: 0 = input region, 1 = filter region.
- `wr_addr`  in  8  row-major word index within the selected region.
- `wr_data`  in  32  FP32 word to write.
- `start`  in  1  single-cycle request to launch a frame.
- `busy`  out  1  high from an accepted `start` until the end of COMPLETE or an error exit.
- `stream_data`  out  32  word driven to the engine's `data_in`.
- `stream_valid`  out  1  high while `stream_data` carries a frame word.
- `stream_last`  out  1  high with the final filter word.
- `conv_done`  in  1  engine `done`.
- `conv_data`  in  32  engine `data_out`.
- `res_rd_addr`  in  8  result word index.
- `res_rd_data`  out  32  result word; 1-cycle read latency.
- `res_count`  out  16  number of words captured in the last frame.
- `frame_done`  out  1  one-cycle pulse when a capture completes.
- `error`  out  1  one-cycle pulse on a rejected config or a timeout.

## Operation
- States are IDLE, SEND, WAIT_DONE, CAPTURE and COMPLETE.
- **Host writes**
  - Writes are accepted only while `busy` is low.
  - A write with `wr_addr` at or above the selected region's depth is dropped.
- **IDLE, on `start`**
  - Sizes are validated first. `start` is rejected if any of these hold: F==0, F>N, N>MAX_IN, F>MAX_F.
  - On rejection: `error` pulses, the state stays IDLE, and `busy` stays low.
  - Otherwise N and F are latched, O=N-F+1 is computed, `busy` rises, and the state moves to SEND.
- **SEND**
  - Input words 0..N*N-1 are emitted first.
  - Filter words 0..F*F-1 follow immediately, with no gaps.
  - `stream_valid` is high for exactly N*N+F*F consecutive cycles.
  - After the last word the state moves to WAIT_DONE.
- **WAIT_DONE**
  - A rising edge on `conv_done` is detected using a registered copy of `conv_done`.
  - On the edge, the state moves to CAPTURE after CAP_DELAY cycles.
  - If no edge arrives within TIMEOUT cycles: `error` pulses and the state returns to IDLE. `res_count` is unchanged.
- **CAPTURE**
  - `conv_data` is written to result[k] for k=0..O*O-1, one word per cycle.
  - After the last word the state moves to COMPLETE.
- **COMPLETE** (one cycle)
  - `res_count` is set to O*O and `frame_done` pulses.
  - `busy` drops and the state returns to IDLE.
- **Rules**
  - `start` while `busy` is ignored.
  - The result buffer is readable in every state. During CAPTURE a read may return either the old or the new word; both are acceptable.
  - Arithmetic: counters are 16 bit. N*N, F*F and O*O are computed as 8x8 unsigned products.
  - No FP arithmetic is done in this block; data passes through bit-exact.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE. Buffer contents are undefined after reset.
- **Start to first word:** `start` accepted at cycle T gives the first `stream_valid` at T+2 (synchronous RAM read).
- **`stream_last`:** high at cycle T+1+N*N+F*F.
- **Capture start:** a `conv_done` edge sampled at cycle D gives the first capture at D+CAP_DELAY.
- **`frame_done`:** asserted one cycle after the last capture.
- **`res_rd_data`:** valid one cycle after `res_rd_addr` is presented.
- **`rst` mid-frame:** immediate return to IDLE, all outputs cleared, no `frame_done` or `error` pulse. The contents of both buffers are preserved.
- **`start` and `wr_en` in the same IDLE cycle:** both are accepted. The write completes before SEND reads that address.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum;
  - `FP_W`=32;
  - the MAX_IN and MAX_F defaults;
  - the address width functions.
- Sub-module `conv_word_ram` is a simple dual-port synchronous RAM: one write port, one registered read port. It is instantiated twice: source buffer (MAX_IN² + MAX_F² words) and result buffer (MAX_IN² words).
- The FSM, counters and edge detector live in the top level.

## Test plan
- **Normal 4x4 frame:** input words 0x3F800000+k, 2x2 filter all 0x40000000, `start`, and a model engine raising `done` after the 20 words.
  - The stream must show 16 input words then 4 filter words in order, with `stream_last` on word 20.
  - 9 words are captured, `res_count`=9 and `frame_done` pulses once.
- **Invalid configs:** F=0, then F=5 with N=8, then N=17.
  - Each gives one `error` pulse, `busy` stays low and `stream_valid` never rises.
- **Timeout:** TIMEOUT=100 and `conv_done` held low.
  - `error` pulses at WAIT_DONE cycle 100, the state returns to IDLE and `res_count` keeps its prior value.
- **Reset mid-SEND:** assert `rst` after word 7.
  - All outputs are 0 on the next edge.
  - A following `start` streams the same source data from word 0.
- **`start` while busy:**
  - A second `start` during SEND is ignored; the word count stays exactly N*N+F*F.
  - A write issued while busy leaves the source unchanged.
- **CAP_DELAY=3 with N=F=1:**
  - A single word is captured exactly 3 cycles after the `done` edge.
  - `res_rd_data` for address 0 matches that word one cycle after the address is presented.
